// File: rtl/mips_pkg.sv
//============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS pipeline front end.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INC    = 4;

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
//============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with write enable and bubble flush.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module if_id_reg
    import mips_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IDIF_write,
    input  logic                 flush,
    input  logic                 valid_in,
    input  logic [BIT_WIDTH-1:0] instr_in,
    input  logic [BIT_WIDTH-1:0] pc_plus4_in,
    output logic [BIT_WIDTH-1:0] id_instr,
    output logic [BIT_WIDTH-1:0] id_pc_plus4,
    output logic                 id_valid
);

    localparam logic [BIT_WIDTH-1:0] c_NOP = BIT_WIDTH'(NOP_INSTR);

    logic [BIT_WIDTH-1:0] r_instr_q,    w_instr_d;
    logic [BIT_WIDTH-1:0] r_pc_plus4_q, w_pc_plus4_d;
    logic                 r_valid_q,    w_valid_d;

    // Flush wins over a held slot so a redirect can always kill the IF/ID entry.
    always_comb begin
        w_instr_d    = r_instr_q;
        w_pc_plus4_d = r_pc_plus4_q;
        w_valid_d    = r_valid_q;
        if (flush) begin
            w_instr_d    = c_NOP;
            w_pc_plus4_d = '0;
            w_valid_d    = 1'b0;
        end else if (IDIF_write) begin
            w_instr_d    = valid_in ? instr_in : c_NOP;
            w_pc_plus4_d = pc_plus4_in;
            w_valid_d    = valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_q    <= '0;
            r_pc_plus4_q <= '0;
            r_valid_q    <= 1'b0;
        end else begin
            r_instr_q    <= w_instr_d;
            r_pc_plus4_q <= w_pc_plus4_d;
            r_valid_q    <= w_valid_d;
        end
    end

    assign id_instr    = r_instr_q;
    assign id_pc_plus4 = r_pc_plus4_q;
    assign id_valid    = r_valid_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//============================================================================
// Module      : fetch_unit
// Description : MIPS instruction fetch: PC, imem request, redirect squash FSM.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module fetch_unit
    import mips_pkg::*;
#(
    parameter int                   BIT_WIDTH = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_PC  = '0,
    parameter int                   DELAY     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PC_write,
    input  logic                 IDIF_write,
    input  logic                 redirect_valid,
    input  logic [BIT_WIDTH-1:0] redirect_pc,
    output logic                 imem_req,
    output logic [BIT_WIDTH-1:0] imem_addr,
    input  logic                 imem_ready,
    input  logic [BIT_WIDTH-1:0] imem_rdata,
    output logic [BIT_WIDTH-1:0] id_instr,
    output logic [BIT_WIDTH-1:0] id_pc_plus4,
    output logic                 id_valid
);

    localparam logic [BIT_WIDTH-1:0] c_ALIGN_MASK = ~(BIT_WIDTH'(3));
    localparam logic [BIT_WIDTH-1:0] c_PC_INC     = BIT_WIDTH'(PC_INC);
    localparam logic [BIT_WIDTH-1:0] c_RESET_PC   = RESET_PC & c_ALIGN_MASK;

    // Register update delay only matters to simulation models; nothing to build.
    generate
        if (DELAY < 0) begin : g_delay_unused
        end
    endgenerate

    fetch_state_t         r_state_q,   w_state_d;
    logic [BIT_WIDTH-1:0] r_pc_q,      w_pc_d;
    logic [BIT_WIDTH-1:0] r_pend_pc_q, w_pend_pc_d;
    logic [BIT_WIDTH-1:0] w_pc_plus4;
    logic [BIT_WIDTH-1:0] w_redirect_aligned;
    logic                 w_flush;
    logic                 w_load_valid;

    assign w_pc_plus4         = r_pc_q + c_PC_INC;
    assign w_redirect_aligned = redirect_pc & c_ALIGN_MASK;

    always_comb begin
        w_state_d    = r_state_q;
        w_pc_d       = r_pc_q;
        w_pend_pc_d  = r_pend_pc_q;
        w_flush      = 1'b0;
        w_load_valid = 1'b0;
        case (r_state_q)
            RUN: begin
                if (redirect_valid) begin
                    w_flush = 1'b1;
                    if (imem_ready) begin
                        w_pc_d = w_redirect_aligned;
                    end else begin
                        w_pend_pc_d = w_redirect_aligned;
                        w_state_d   = SQUASH;
                    end
                end else if (imem_ready && PC_write && IDIF_write) begin
                    w_load_valid = 1'b1;
                    w_pc_d       = w_pc_plus4;
                end
                // Every other case leaves the PC alone so the response is
                // re-fetched; the IF/ID register holds or bubbles on IDIF_write.
            end
            SQUASH: begin
                if (redirect_valid) begin
                    w_pend_pc_d = w_redirect_aligned;
                    w_flush     = 1'b1;
                end
                if (imem_ready) begin
                    w_pc_d    = redirect_valid ? w_redirect_aligned : r_pend_pc_q;
                    w_state_d = RUN;
                end
            end
            default: begin
                w_state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= RUN;
            r_pc_q      <= c_RESET_PC;
            r_pend_pc_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_pc_q      <= w_pc_d;
            r_pend_pc_q <= w_pend_pc_d;
        end
    end

    // In SQUASH the PC is still the stale address, so the request stays stable.
    assign imem_req  = ~rst;
    assign imem_addr = r_pc_q;

    if_id_reg #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .IDIF_write  (IDIF_write),
        .flush       (w_flush),
        .valid_in    (w_load_valid),
        .instr_in    (imem_rdata),
        .pc_plus4_in (w_pc_plus4),
        .id_instr    (id_instr),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_write;
    logic        IDIF_write;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0001;
        return {16'hA5A5, a[15:0]};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_unit #(
        .BIT_WIDTH (32),
        .RESET_PC  (32'h0),
        .DELAY     (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PC_write       (PC_write),
        .IDIF_write     (IDIF_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .id_instr       (id_instr),
        .id_pc_plus4    (id_pc_plus4),
        .id_valid       (id_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; PC_write = 1'b1; IDIF_write = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; imem_ready = 1'b1;
        tick(); tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", id_instr); end
        checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL rst_pc4 got=%h exp=0", id_pc_plus4); end
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL req_after_rst got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL addr0 got=%h exp=0", imem_addr); end
        tick();
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL addr4 got=%h exp=4", imem_addr); end
        checks++; if (id_instr !== 32'h2008_0001) begin failures++; $display("FAIL first_instr got=%h exp=20080001", id_instr); end
        checks++; if (id_pc_plus4 !== 32'h4) begin failures++; $display("FAIL first_pc4 got=%h exp=4", id_pc_plus4); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", id_valid); end
        tick();
        checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL addr8 got=%h exp=8", imem_addr); end
        checks++; if (id_instr !== 32'hA5A5_0004) begin failures++; $display("FAIL second_instr got=%h exp=a5a50004", id_instr); end
    endtask

    task automatic test_load_use_stall();
        tick(); tick();
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL stall_pre_addr got=%h exp=10", imem_addr); end
        PC_write = 1'b0; IDIF_write = 1'b0;
        tick();
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL stall_addr got=%h exp=10", imem_addr); end
        checks++; if (id_instr !== 32'hA5A5_000C) begin failures++; $display("FAIL stall_hold_instr got=%h exp=a5a5000c", id_instr); end
        checks++; if (id_pc_plus4 !== 32'h10) begin failures++; $display("FAIL stall_hold_pc4 got=%h exp=10", id_pc_plus4); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stall_hold_valid got=%b exp=1", id_valid); end
        PC_write = 1'b1; IDIF_write = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h14) begin failures++; $display("FAIL post_stall_addr got=%h exp=14", imem_addr); end
        checks++; if (id_instr !== 32'hA5A5_0010) begin failures++; $display("FAIL post_stall_instr got=%h exp=a5a50010", id_instr); end
        checks++; if (id_pc_plus4 !== 32'h14) begin failures++; $display("FAIL post_stall_pc4 got=%h exp=14", id_pc_plus4); end
    endtask

    task automatic test_redirect_ready();
        tick(); tick(); tick();
        checks++; if (imem_addr !== 32'h20) begin failures++; $display("FAIL redir_pre_addr got=%h exp=20", imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_bubble_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL redir_bubble_instr got=%h exp=0", id_instr); end
        tick();
        checks++; if (id_instr !== 32'hA5A5_0100) begin failures++; $display("FAIL redir_target_instr got=%h exp=a5a50100", id_instr); end
        checks++; if (id_pc_plus4 !== 32'h104) begin failures++; $display("FAIL redir_target_pc4 got=%h exp=104", id_pc_plus4); end
        checks++; if (imem_addr !== 32'h104) begin failures++; $display("FAIL redir_next_addr got=%h exp=104", imem_addr); end
    endtask

    task automatic test_redirect_wait();
        redirect_valid = 1'b1; redirect_pc = 32'h30;
        tick();
        imem_ready = 1'b0; redirect_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            tick();
            redirect_valid = 1'b0;
            checks++; if (imem_addr !== 32'h30) begin failures++; $display("FAIL wait_addr[%0d] got=%h exp=30", i, imem_addr); end
            checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL wait_valid[%0d] got=%b exp=0", i, id_valid); end
        end
        imem_ready = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL squash_target_addr got=%h exp=200", imem_addr); end
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL squash_discard_valid got=%b exp=0", id_valid); end
        tick();
        checks++; if (id_instr !== 32'hA5A5_0200) begin failures++; $display("FAIL squash_target_instr got=%h exp=a5a50200", id_instr); end
        checks++; if (id_pc_plus4 !== 32'h204) begin failures++; $display("FAIL squash_target_pc4 got=%h exp=204", id_pc_plus4); end
    endtask

    task automatic test_double_redirect();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_pc = 32'h300;
        checks++; if (imem_addr !== 32'h204) begin failures++; $display("FAIL dbl_hold_addr got=%h exp=204", imem_addr); end
        tick();
        redirect_valid = 1'b0; imem_ready = 1'b1;
        tick();
        checks++; if (imem_addr !== 32'h300) begin failures++; $display("FAIL dbl_addr got=%h exp=300", imem_addr); end
        tick();
        checks++; if (id_instr !== 32'hA5A5_0300) begin failures++; $display("FAIL dbl_instr got=%h exp=a5a50300", id_instr); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL dbl_valid got=%b exp=1", id_valid); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_start_addr got=%h exp=fffffffc", imem_addr); end
        tick();
        checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL wrap_pc4 got=%h exp=0", id_pc_plus4); end
        checks++; if (id_instr !== 32'hA5A5_FFFC) begin failures++; $display("FAIL wrap_instr got=%h exp=a5a5fffc", id_instr); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_reset_in_squash();
        tick();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0; rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL sq_rst_req got=%b exp=0", imem_req); end
        tick();
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL sq_rst_valid got=%b exp=0", id_valid); end
        checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL sq_rst_instr got=%h exp=0", id_instr); end
        checks++; if (id_pc_plus4 !== 32'h0) begin failures++; $display("FAIL sq_rst_pc4 got=%h exp=0", id_pc_plus4); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL sq_rst_addr got=%h exp=0", imem_addr); end
        rst = 1'b0; imem_ready = 1'b1;
        tick();
        checks++; if (id_instr !== 32'h2008_0001) begin failures++; $display("FAIL sq_rst_first_instr got=%h exp=20080001", id_instr); end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL sq_rst_first_valid got=%b exp=1", id_valid); end
        checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL sq_rst_next_addr got=%h exp=4", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_load_use_stall();
        test_redirect_ready();
        test_redirect_wait();
        test_double_redirect();
        test_wrap();
        test_reset_in_squash();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, issues requests to instruction memory over a ready handshake, and drives the IF/ID pipeline register consumed by decode. It obeys the `PC_write` and `IDIF_write` stall controls from `hazard_detection_unit`. It accepts branch/jump redirects from ID, and squashes any instruction-memory response that is in flight when a redirect arrives.

## Interface
Parameters:
- `BIT_WIDTH`, 32: datapath, PC and instruction width.
- `RESET_PC`, 0: PC value after reset. Bits [1:0] are ignored.
- `DELAY`, 0: simulation-only delay on register updates. Ignored by synthesis.

Ports:
- `clk` in, 1: the single clock. All state updates on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `PC_write` in, 1: from the hazard unit. 0 freezes the PC.
- `IDIF_write` in, 1: from the hazard unit. 0 holds the IF/ID register.
- `redirect_valid` in, 1: a taken branch or jump resolved in ID.
- `redirect_pc` in, BIT_WIDTH: target of the redirect.
- `imem_req` out, 1: fetch request to instruction memory.
- `imem_addr` out, BIT_WIDTH: fetch address. Word aligned.
- `imem_ready` in, 1: memory has accepted the request and `imem_rdata` is valid in this cycle.
- `imem_rdata` in, BIT_WIDTH: instruction word.
- `id_instr` out, BIT_WIDTH: IF/ID instruction. NOP (all zeros) when the slot is a bubble.
- `id_pc_plus4` out, BIT_WIDTH: IF/ID PC+4.
- `id_valid` out, 1: the IF/ID slot holds a real instruction.

## Operation
State machine:
- RUN: `imem_addr`=`pc`. A response is used if it arrives.
- SQUASH: `imem_addr`=the stale `pc`. The response is discarded when it arrives.

Request rules:
- `imem_req`=1 in every cycle where `rst`=0.
- `imem_addr` is held stable until `imem_ready`=1.

Behaviour in RUN, in priority order:
- If `redirect_valid`=1 and `imem_ready`=1:
  - Discard `imem_rdata`.
  - `pc`<=`redirect_pc`.
  - IF/ID <= bubble.
  - Stay in RUN.
- If `redirect_valid`=1 and `imem_ready`=0:
  - `pend_pc`<=`redirect_pc`.
  - IF/ID <= bubble.
  - Go to SQUASH.
- If `imem_ready`=1, `PC_write`=1 and `IDIF_write`=1:
  - IF/ID <= {`imem_rdata`, `pc`+4, valid=1}.
  - `pc`<=`pc`+4.
- If `imem_ready`=1 and `PC_write`=0:
  - Drop the response. It is re-fetched next cycle.
  - `pc` is held.
  - IF/ID is held if `IDIF_write`=0, otherwise it loads a bubble.
- If `imem_ready`=0:
  - `pc` is held.
  - IF/ID loads a bubble if `IDIF_write`=1, otherwise it is held.

Behaviour in SQUASH:
- `redirect_valid`=1 overwrites `pend_pc` (latest redirect wins).
- On `imem_ready`=1: discard the data, `pc`<=`pend_pc` (or `redirect_pc` if a redirect is asserted in the same cycle), go to RUN.
- IF/ID loads a bubble when `IDIF_write`=1, otherwise it is held.

Redirect rules:
- A redirect overrides `PC_write`=0 and `IDIF_write`=0.
- ID asserts `redirect_valid` only in cycles where the branch advances. This is the protocol contract; the bench may assume it.

Arithmetic:
- `pc`+4 wraps modulo 2^BIT_WIDTH.
- `pc`[1:0] and `pend_pc`[1:0] are forced to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, `pend_pc`=0, state=RUN, `id_instr`=0, `id_pc_plus4`=0, `id_valid`=0, `imem_req`=0 while `rst`=1.
- Reset during SQUASH abandons the squash. The next request after reset is to `RESET_PC`.
- Latency:
  - Zero-wait memory gives one instruction per cycle.
  - IF/ID outputs are registered: the response accepted in cycle N appears on the IF/ID outputs in cycle N+1.
- Redirect penalty is one bubble with a ready memory, plus the outstanding wait when in SQUASH.
- `imem_req` and `imem_addr` are combinational from the registered state. They have no path from `redirect_valid`.

## Structure
- Shared package `mips_pkg` holds:
  - the `fetch_state_t` enum (RUN, SQUASH);
  - `NOP_INSTR`=32'h0000_0000;
  - the `PC_INC`=4 constant.
- Sub-module `if_id_reg`:
  - Inputs: `IDIF_write`, flush/bubble, and the instruction/PC+4 pair.
  - Outputs: the three `id_*` signals.
  - Reused by the flush path in decode.
- The top level holds the PC register, `pend_pc`, the FSM, and the request logic.

## Test plan
- **Reset.** Reset, then zero-wait memory returning `0x20080001` at 0x0. Expected:
  - `imem_addr` sequence 0x0, 0x4, 0x8;
  - `id_instr`=0x20080001 with `id_pc_plus4`=0x4 one cycle after acceptance.
- **Load-use stall.** `PC_write`=`IDIF_write`=0 for 1 cycle at `pc`=0x10. Expected:
  - `imem_addr` is 0x10 for 2 cycles;
  - IF/ID holds the instruction from 0xC;
  - no instruction is lost or duplicated.
- **Redirect with ready memory.** Redirect to 0x100 at `pc`=0x20 with `imem_ready`=1. Expected:
  - next `imem_addr`=0x100;
  - `id_valid`=0 for one cycle;
  - 0x20 is never delivered.
- **Redirect during a wait.** Redirect to 0x200 while a fetch of 0x30 is waiting (`imem_ready`=0 for 3 cycles). Expected:
  - `imem_addr` stays at 0x30 until ready;
  - its data is discarded;
  - next `imem_addr`=0x200.
- **Double redirect.** Second redirect to 0x300 during SQUASH. Expected: after ready, `imem_addr`=0x300, not 0x200.
- **Wrap and reset mid-operation.**
  - Start at `pc`=0xFFFF_FFFC: `id_pc_plus4`=0x0 and the next fetch is at 0x0.
  - Assert `rst` during SQUASH: all outputs take their reset values the next cycle.
